// File: rtl/mult_mem_pkg.sv
// Shared constants and scheduler state encoding for the product memory and its clients.
package mult_mem_pkg;

  localparam int unsigned MEM_DEPTH  = 64;
  localparam int unsigned MEM_ADDR_W = 6;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/mult_mem_sched_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips only on contended cycles.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  // 1 = requester 0 won the last contended cycle, so requester 1 goes first next time
  logic last_grant;
  logic contend;

  assign contend = req[0] & req[1];

  always_comb begin
    gnt_c = req;
    if (contend) begin
      gnt_c = last_grant ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b0;
    end else if (contend) begin
      last_grant <= gnt_c[0];
    end
  end

endmodule

// File: rtl/mult_mem_sched.sv
// Single-port product memory scheduler: arbitrates multiplier writes against a read-burst engine.
module mult_mem_sched
  import mult_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned DEPTH  = MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_len,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  sched_state_t      state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W:0]   remain, remain_nxt;
  logic              rd_req, wr_win, rd_win;
  logic              p1_valid, p1_last;
  logic              last_rd;

  assign rd_req  = (state == BURST) && (remain != '0);
  assign last_rd = (remain == (ADDR_W+1)'(1));
  assign rd_busy = (state != IDLE);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({rd_req, wr_req}),
    .gnt_c ({rd_win, wr_win})
  );

  // Memory port; forced quiet while reset is asserted
  always_comb begin
    wr_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst) begin
      if (wr_win) begin
        wr_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end else if (rd_win) begin
        mem_en   = 1'b1;
        mem_addr = ptr;
      end
    end
  end

  // Burst sequencing; DRAIN holds busy through the cycle that carries rd_done
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    remain_nxt = remain;
    case (state)
      IDLE: begin
        if (rd_start && (rd_len != '0) && (rd_len <= (ADDR_W+1)'(DEPTH))) begin
          ptr_nxt    = rd_base;
          remain_nxt = rd_len;
          state_nxt  = BURST;
        end
      end
      BURST: begin
        if (rd_win) begin
          ptr_nxt    = ptr + ADDR_W'(1);
          remain_nxt = remain - (ADDR_W+1)'(1);
          if (last_rd) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rd_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      remain <= remain_nxt;
    end
  end

  // Read return: p1_* mirrors the read whose data is on mem_rdata this cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      rd_data  <= '0;
    end else begin
      p1_valid <= rd_win;
      p1_last  <= rd_win & last_rd;
      rd_valid <= p1_valid;
      rd_done  <= p1_valid & p1_last;
      if (p1_valid) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mult_mem_sched.sv
// Directed vector bench for mult_mem_sched with a behavioural single-port memory.
module tb_mult_mem_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;
  logic        rd_start;
  logic [5:0]  rd_base;
  logic [6:0]  rd_len;
  logic        rd_busy, rd_valid, rd_done;
  logic [31:0] rd_data;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [64];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_mem_sched dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        wr_req;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_start;
    logic [5:0]  rd_base;
    logic [6:0]  rd_len;
    logic        e_gnt, e_en, e_we;
    logic [5:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_busy, e_valid;
    logic [31:0] e_data;
    logic        e_done;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input int wq, input int wa, input int wd,
                             input int rs, input int rb, input int rl,
                             input int g, input int en, input int we,
                             input int ma, input int mw,
                             input int bz, input int vl, input int dt, input int dn);
    vec_t r;
    r.wr_req = 1'(wq);  r.wr_addr = 6'(wa);  r.wr_data = 32'(wd);
    r.rd_start = 1'(rs); r.rd_base = 6'(rb); r.rd_len = 7'(rl);
    r.e_gnt = 1'(g); r.e_en = 1'(en); r.e_we = 1'(we);
    r.e_addr = 6'(ma); r.e_wdata = 32'(mw);
    r.e_busy = 1'(bz); r.e_valid = 1'(vl); r.e_data = 32'(dt); r.e_done = 1'(dn);
    return r;
  endfunction

  task automatic apply(input vec_t x);
    wr_req = x.wr_req; wr_addr = x.wr_addr; wr_data = x.wr_data;
    rd_start = x.rd_start; rd_base = x.rd_base; rd_len = x.rd_len;
  endtask

  task automatic cmp(input string nm, input string f, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", nm, f, got, want);
    end
  endtask

  task automatic check(input string nm, input vec_t e);
    n_vec++;
    cmp(nm, "wr_gnt",    32'(wr_gnt),   32'(e.e_gnt));
    cmp(nm, "mem_en",    32'(mem_en),   32'(e.e_en));
    cmp(nm, "mem_we",    32'(mem_we),   32'(e.e_we));
    cmp(nm, "mem_addr",  32'(mem_addr), 32'(e.e_addr));
    cmp(nm, "mem_wdata", mem_wdata,     e.e_wdata);
    cmp(nm, "rd_busy",   32'(rd_busy),  32'(e.e_busy));
    cmp(nm, "rd_valid",  32'(rd_valid), 32'(e.e_valid));
    cmp(nm, "rd_data",   rd_data,       e.e_data);
    cmp(nm, "rd_done",   32'(rd_done),  32'(e.e_done));
  endtask

  // One cycle: drive just after the edge, sample at the falling edge
  task automatic step(input string nm, input vec_t x);
    @(posedge clk); #1;
    apply(x);
    @(negedge clk);
    check(nm, x);
  endtask

  initial begin
    vec_t z;
    z = v(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0,0);

    // writes 0..5 <- 10..15
    for (int i = 0; i < 6; i++) tv.push_back(v(1,i,10+i, 0,0,0, 1,1,1,i,10+i, 0,0,0,0));
    // burst base 0 len 4
    tv.push_back(v(0,0,0, 1,0,4, 0,0,0,0,0, 0,0,0,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,1,0,0,0, 1,0,0,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,1,0,1,0, 1,0,0,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,1,0,2,0, 1,1,10,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,1,0,3,0, 1,1,11,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,0,0,0,0, 1,1,12,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,0,0,0,0, 1,1,13,1));
    tv.push_back(v(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,13,0));
    // contention: writes held while burst base 0 len 3 runs -> W R W R W R
    tv.push_back(v(1,6,'h66,  1,0,3, 1,1,1,6,'h66,  0,0,13,0));
    tv.push_back(v(1,7,'h77,  0,0,0, 1,1,1,7,'h77,  1,0,13,0));
    tv.push_back(v(1,8,'h88,  0,0,0, 0,1,0,0,0,     1,0,13,0));
    tv.push_back(v(1,8,'h88,  0,0,0, 1,1,1,8,'h88,  1,0,13,0));
    tv.push_back(v(1,9,'h99,  0,0,0, 0,1,0,1,0,     1,1,10,0));
    tv.push_back(v(1,9,'h99,  0,0,0, 1,1,1,9,'h99,  1,0,10,0));
    tv.push_back(v(1,10,'hAA, 0,0,0, 0,1,0,2,0,     1,1,11,0));
    tv.push_back(v(1,10,'hAA, 0,0,0, 1,1,1,10,'hAA, 1,0,11,0));
    tv.push_back(v(0,0,0,     0,0,0, 0,0,0,0,0,     1,1,12,1));
    tv.push_back(v(0,0,0,     0,0,0, 0,0,0,0,0,     0,0,12,0));
    // wrap: 62,63,0 <- A,B,C then burst base 62 len 3
    tv.push_back(v(1,62,'hA, 0,0,0,  1,1,1,62,'hA, 0,0,12,0));
    tv.push_back(v(1,63,'hB, 0,0,0,  1,1,1,63,'hB, 0,0,12,0));
    tv.push_back(v(1,0,'hC,  0,0,0,  1,1,1,0,'hC,  0,0,12,0));
    tv.push_back(v(0,0,0,    1,62,3, 0,0,0,0,0,    0,0,12,0));
    tv.push_back(v(0,0,0,    0,0,0,  0,1,0,62,0,   1,0,12,0));
    tv.push_back(v(0,0,0,    0,0,0,  0,1,0,63,0,   1,0,12,0));
    tv.push_back(v(0,0,0,    0,0,0,  0,1,0,0,0,    1,1,'hA,0));
    tv.push_back(v(0,0,0,    0,0,0,  0,0,0,0,0,    1,1,'hB,0));
    tv.push_back(v(0,0,0,    0,0,0,  0,0,0,0,0,    1,1,'hC,1));
    tv.push_back(v(0,0,0,    0,0,0,  0,0,0,0,0,    0,0,'hC,0));
    // zero-length start is ignored
    tv.push_back(v(0,0,0, 1,5,0, 0,0,0,0,0, 0,0,'hC,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,'hC,0));
    // starts while busy are ignored: exactly two words from base 1
    tv.push_back(v(0,0,0, 1,1,2, 0,0,0,0,0, 0,0,'hC,0));
    tv.push_back(v(0,0,0, 1,3,5, 0,1,0,1,0, 1,0,'hC,0));
    tv.push_back(v(0,0,0, 1,3,5, 0,1,0,2,0, 1,0,'hC,0));
    tv.push_back(v(0,0,0, 1,3,5, 0,0,0,0,0, 1,1,11,0));
    tv.push_back(v(0,0,0, 1,3,5, 0,0,0,0,0, 1,1,12,1));
    tv.push_back(v(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,12,0));
    tv.push_back(v(0,0,0, 0,0,0, 0,0,0,0,0, 0,0,12,0));

    // reset state, with a write request pending to show grants are held off
    rst = 1'b0;
    apply(z);
    wr_req = 1'b1; wr_addr = 6'd5; wr_data = 32'h55;
    repeat (2) @(negedge clk);
    check("reset", z);
    apply(z);
    rst = 1'b1;

    for (int i = 0; i < tv.size(); i++) step($sformatf("vec%0d", i), tv[i]);

    // reset mid-burst: one contended write win first, so priority points at the reader
    step("g0", v(0,0,0,     1,0,5, 0,0,0,0,0,     0,0,12,0));
    step("g1", v(1,30,'h30, 0,0,0, 1,1,1,30,'h30, 1,0,12,0));
    step("g2", v(0,0,0,     0,0,0, 0,1,0,0,0,     1,0,12,0));
    step("g3", v(0,0,0,     0,0,0, 0,1,0,1,0,     1,0,12,0));
    @(posedge clk); #1;
    n_vec++;
    cmp("g4_pre", "rd_valid", 32'(rd_valid), 32'd1);
    cmp("g4_pre", "rd_data",  rd_data,       32'hC);
    #1;
    rst = 1'b0;
    wr_req = 1'b1; wr_addr = 6'd40; wr_data = 32'h40;
    #1;
    check("rst_async", z);
    @(negedge clk); check("rst_hold0", z);
    @(negedge clk); check("rst_hold1", z);
    apply(z);
    rst = 1'b1;
    step("r0", v(1,20,'h20, 1,0,2, 1,1,1,20,'h20, 0,0,0,0));
    step("r1", v(1,21,'h21, 0,0,0, 1,1,1,21,'h21, 1,0,0,0));
    step("r2", v(0,0,0,     0,0,0, 0,1,0,0,0,     1,0,0,0));
    step("r3", v(0,0,0,     0,0,0, 0,1,0,1,0,     1,0,0,0));
    step("r4", v(0,0,0,     0,0,0, 0,0,0,0,0,     1,1,'hC,0));
    step("r5", v(0,0,0,     0,0,0, 0,0,0,0,0,     1,1,11,1));
    step("r6", v(0,0,0,     0,0,0, 0,0,0,0,0,     0,0,11,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
